// File: rtl/rr_arb_pkg.sv
// Shared encodings for the 2:1 round-robin packet arbiter.
// Kept separate so the select mux datapath can decode sel identically.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/out_reg_stage.sv
// Single registered valid/ready output stage (no skid buffer).
// ld tells upstream a new beat may be captured this cycle.
module out_reg_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  input  logic              y_ready,
  output logic              ld,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              sel
);

  import rr_arb_pkg::*;

  assign ld = ~y_valid | y_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      sel     <= SEL_A;
    end else if (load) begin
      y_valid <= 1'b1;
      y_data  <= in_data;
      y_last  <= in_last;
      sel     <= in_sel;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-channel round-robin packet arbiter feeding one output register.
// A granted multi-beat packet keeps the grant until its last beat.
module rr_arb_2to1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              sel,
  input  logic              y_ready
);

  import rr_arb_pkg::*;

  state_t state;
  logic   last_grant;
  logic   ld;
  logic   grant_a;
  logic   grant_b;
  logic   a_xfer;
  logic   b_xfer;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      state == ST_LOCK_A: grant_a = 1'b1;
      state == ST_LOCK_B: grant_b = 1'b1;
      default: begin
        grant_a = a_valid &
                  (~b_valid | last_grant == SEL_B);
        grant_b = b_valid &
                  (~a_valid | last_grant == SEL_A);
      end
    endcase
  end

  // Readies are forced low while reset is held.
  assign a_ready = ld & grant_a & ~rst;
  assign b_ready = ld & grant_b & ~rst;
  assign a_xfer  = a_valid & a_ready;
  assign b_xfer  = b_valid & b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SEL_B;
    end else begin
      if (a_xfer)
        last_grant <= SEL_A;
      else if (b_xfer)
        last_grant <= SEL_B;
      unique case (state)
        ST_IDLE: begin
          if (a_xfer & ~a_last)
            state <= ST_LOCK_A;
          else if (b_xfer & ~b_last)
            state <= ST_LOCK_B;
        end
        ST_LOCK_A:
          if (a_xfer & a_last) state <= ST_IDLE;
        ST_LOCK_B:
          if (b_xfer & b_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  out_reg_stage #(.DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (a_xfer | b_xfer),
    .in_data (b_xfer ? b_data : a_data),
    .in_last (b_xfer ? b_last : a_last),
    .in_sel  (b_xfer ? SEL_B : SEL_A),
    .y_ready (y_ready),
    .ld      (ld),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .sel     (sel)
  );

endmodule

// File: doc/rr_arb_2to1.md
Name: rr_arb_2to1

Overview:
- Two-channel round-robin packet arbiter. Sits directly upstream of the 2:1 select mux datapath.
- Decides which of channel a or channel b is forwarded, and produces the select (`sel`: 0 = a, 1 = b).
- Forwards the granted beat through one registered valid/ready output stage.
- Packet-aware: once a multi-beat packet is granted, the grant is held until its last beat.

Parameters:
- DATA_W, 8, width of data on each input channel and on the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  channel a beat valid.
- a_data  input  DATA_W  channel a beat data.
- a_last  input  1  channel a final beat of packet.
- a_ready  output  1  channel a beat accepted this cycle (when a_valid is also high).
- b_valid  input  1  channel b beat valid.
- b_data  input  DATA_W  channel b beat data.
- b_last  input  1  channel b final beat of packet.
- b_ready  output  1  channel b beat accepted this cycle (when b_valid is also high).
- y_valid  output  1  output register holds a beat.
- y_data  output  DATA_W  registered beat data.
- y_last  output  1  registered last flag.
- sel  output  1  source of the held beat (0 = a, 1 = b).
- y_ready  input  1  downstream consumes the held beat.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - y_valid=0, y_data=0, y_last=0, sel=0.
  - state=IDLE.
  - last_grant=1, so a wins the first contention.
- Load enable: ld = ~y_valid | y_ready (combinational).
  - a_ready and b_ready depend combinationally on y_ready; there is no skid buffer.
- Transfers:
  - Channel a transfers when a_valid & a_ready; channel b likewise.
  - At most one channel transfers per cycle; a_ready & b_ready is never 1.
- FSM states: IDLE, LOCK_A, LOCK_B.
  - IDLE, arbitration:
    - Only a valid: grant a.
    - Only b valid: grant b.
    - Both valid: grant the channel ≠ last_grant.
    - Neither valid: no grant.
    - a_ready = ld & grant_a; b_ready = ld & grant_b.
  - IDLE, on a transfer from channel X:
    - Update last_grant to X.
    - If X_last=0, go to LOCK_X; if X_last=1, stay in IDLE.
  - LOCK_A: a_ready = ld; b_ready = 0, regardless of b_valid. On an a transfer with a_last=1, go to IDLE.
  - LOCK_B: symmetric to LOCK_A.
  - A bubble (valid low) inside a locked packet holds the lock indefinitely.
- Output register:
  - On a transfer: y_data/y_last/sel load the granted channel's data/last/index, and y_valid=1. Latency is exactly 1 cycle from input handshake to y_valid.
  - No transfer and y_ready=1: y_valid←0. y_data/y_last/sel hold their values.
  - Back-to-back: a transfer in the same cycle as y_ready=1 replaces the held beat, giving full throughput of one beat per cycle.
  - y_ready=0 with y_valid=1: held beat and sel are stable; both ready outputs are 0.
- Boundaries:
  - Reset asserted mid-packet: lock is dropped and the held beat is discarded. Upstream must restart the packet.
  - Valid deasserted while ready=0: allowed, with no side effect.
  - Single-beat packets (last=1 on every beat) from both channels: strict alternation a,b,a,b.

Decomposition:
- Shared package rr_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_LOCK_A=2'd1, ST_LOCK_B=2'd2.
  - Select constants SEL_A=1'b0, SEL_B=1'b1.
- One natural sub-module, out_reg_stage (parameter DATA_W):
  - Holds y_valid/y_data/y_last/sel.
  - Exports ld.
- Arbitration FSM and ready generation stay in the top.

Test Plan:
- Reset check: hold rst 2 cycles with all valids high → a_ready=b_ready=0 during reset, then y_valid=0, y_data=0, sel=0.
- Single-beat contention:
  - Stimulus: a_valid=b_valid=1, last=1, y_ready=1 constant; a_data=8'hA0+n, b_data=8'hB0+n.
  - Required: y_data sequence A0,B0,A1,B1…, sel 0,1,0,1, each 1 cycle after its handshake.
- Packet lock:
  - Stimulus: a sends 3-beat packet (last on beat 3) while b_valid=1 throughout.
  - Required: b_ready=0 for all 3 a beats; first b beat appears on y the cycle after a's last beat, with sel=1.
- Backpressure:
  - Stimulus: y_ready=0 for 4 cycles with y_valid=1 (y_data=8'h55).
  - Required: y_data stays 8'h55, a_ready=b_ready=0; when y_ray_ready returns to 1, the next beat loads in that same cycle.
- Lock bubble: b packet beat 1 (last=0), then b_valid=0 for 3 cycles while a_valid=1 → state stays LOCK_B, a_ready=0; b beat 2 (last=1) then releases to a.
- Reset mid-packet: rst during LOCK_A with y_valid=1 → next cycle y_valid=0, state IDLE; a fresh b_valid alone is granted immediately.
